// File: rtl/phase_sweep_ctl.sv
// -----------------------------------------------------------------------------
// phase_sweep_ctl
//
// Purpose:
//   Steps the I/Q demodulator phase offset through STEPS equally spaced values.
//   At each offset the first SETTLE_N result strobes are thrown away, then
//   2^AVG_LOG2 magnitude results are summed. Each step's sum is reported, the
//   strongest offset is tracked, and at the end of the sweep the phase is
//   parked on the best offset so the demodulator runs phase-aligned.
//
// Ports:
//   i_clk          system clock
//   i_rst_in       asynchronous active-high reset
//   i_start        one-cycle request to begin a sweep (ignored while busy)
//   i_abort        synchronous sweep cancel (ignored in IDLE)
//   o_phase        phase offset driven to the demodulator
//   i_demod_rdy    one-cycle strobe, i_demod_value valid
//   i_demod_value  unsigned demodulator magnitude result
//   o_busy         sweep in progress
//   o_done         one-cycle pulse, sweep complete
//   o_step_valid   one-cycle pulse, o_step_idx / o_step_mag valid
//   o_step_idx     index of the reported step
//   o_step_mag     accumulated magnitude of the reported step
//   o_best_phase   phase of the strongest step so far
//   o_best_mag     magnitude of the strongest step so far
// -----------------------------------------------------------------------------
module phase_sweep_ctl #(
  parameter int unsigned STEPS       = 16,
  parameter logic [15:0] PHASE_START = 16'h0000,
  parameter logic [15:0] PHASE_STEP  = 16'h1000,
  parameter int unsigned SETTLE_N    = 1,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_in,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic [15:0]           o_phase,
  input  logic                  i_demod_rdy,
  input  logic [7:0]            i_demod_value,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_step_valid,
  output logic [7:0]            o_step_idx,
  output logic [8+AVG_LOG2-1:0] o_step_mag,
  output logic [15:0]           o_best_phase,
  output logic [8+AVG_LOG2-1:0] o_best_mag
);

  // Sum of 2^AVG_LOG2 eight-bit values needs 8+AVG_LOG2 bits, so it never wraps.
  localparam int unsigned ACC_W    = 8 + AVG_LOG2;
  localparam logic [7:0]  LAST_IDX = 8'(STEPS - 1);
  localparam logic [4:0]  ACC_LAST = 5'((32'd1 << AVG_LOG2) - 32'd1);
  localparam logic [3:0]  SETTLE_LD = 4'(SETTLE_N);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_ACCUM   = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [15:0]        r_phase;
  logic [15:0]        r_best_phase;
  logic [ACC_W-1:0]   r_best_mag;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_step_mag;
  logic [7:0]         r_step_idx;
  logic [3:0]         r_disc_cnt;
  logic [4:0]         r_acc_cnt;

  logic [ACC_W-1:0]   w_acc_sum;
  logic               w_acc_last;
  logic               w_settle_last;
  logic               w_busy;
  logic               w_done;
  logic               w_step_valid;

  assign w_acc_sum     = r_acc + ACC_W'(i_demod_value);
  assign w_acc_last    = (r_acc_cnt == ACC_LAST);
  assign w_settle_last = (r_disc_cnt == 4'd1);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst_in) begin
    if (i_rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort beats every other transition outside IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (SETTLE_LD == 4'd0) begin
            w_next_state = S_ACCUM;
          end else begin
            w_next_state = S_SETTLE;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (i_demod_rdy && w_settle_last) begin
          w_next_state = S_ACCUM;
        end else begin
          w_next_state = S_SETTLE;
        end
      end
      S_ACCUM: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (i_demod_rdy && w_acc_last) begin
          w_next_state = S_COMPARE;
        end else begin
          w_next_state = S_ACCUM;
        end
      end
      S_COMPARE: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (r_step_idx == LAST_IDX) begin
          w_next_state = S_DONE;
        end else if (SETTLE_LD == 4'd0) begin
          w_next_state = S_ACCUM;
        end else begin
          w_next_state = S_SETTLE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_step_valid = 1'b0;
    case (r_state)
      S_IDLE:    w_busy       = 1'b0;
      S_COMPARE: w_step_valid = 1'b1;
      S_DONE:    w_done       = 1'b1;
      default:   w_busy       = 1'b1;
    endcase
  end

  // Sweep datapath: phase, counters, accumulator and best-offset tracking.
  always_ff @(posedge i_clk or posedge i_rst_in) begin
    if (i_rst_in) begin
      r_phase      <= PHASE_START;
      r_best_phase <= PHASE_START;
      r_best_mag   <= '0;
      r_acc        <= '0;
      r_step_mag   <= '0;
      r_step_idx   <= 8'd0;
      r_disc_cnt   <= 4'd0;
      r_acc_cnt    <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_phase      <= PHASE_START;
            r_best_phase <= PHASE_START;
            r_best_mag   <= '0;
            r_acc        <= '0;
            r_step_idx   <= 8'd0;
            r_disc_cnt   <= SETTLE_LD;
            r_acc_cnt    <= 5'd0;
          end
        end
        S_SETTLE: begin
          if (!i_abort && i_demod_rdy) begin
            r_disc_cnt <= r_disc_cnt - 4'd1;
          end
        end
        S_ACCUM: begin
          if (!i_abort && i_demod_rdy) begin
            r_acc     <= w_acc_sum;
            r_acc_cnt <= r_acc_cnt + 5'd1;
            // Load the report register early so it already holds the step
            // sum during the COMPARE cycle in which step_valid is high.
            if (w_acc_last) begin
              r_step_mag <= w_acc_sum;
            end
          end
        end
        S_COMPARE: begin
          if (!i_abort) begin
            // Strict compare: on a tie the earlier step keeps the title.
            if (r_acc > r_best_mag) begin
              r_best_mag   <= r_acc;
              r_best_phase <= r_phase;
            end
            if (r_step_idx != LAST_IDX) begin
              r_phase    <= r_phase + PHASE_STEP;
              r_step_idx <= r_step_idx + 8'd1;
              r_acc      <= '0;
              r_acc_cnt  <= 5'd0;
              r_disc_cnt <= SETTLE_LD;
            end
          end
        end
        S_DONE: begin
          // best_phase already includes any update from the last COMPARE.
          if (!i_abort) begin
            r_phase <= r_best_phase;
          end
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  assign o_phase      = r_phase;
  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_step_valid = w_step_valid;
  assign o_step_idx   = r_step_idx;
  assign o_step_mag   = r_step_mag;
  assign o_best_phase = r_best_phase;
  assign o_best_mag   = r_best_mag;

endmodule

// File: doc/phase_sweep_ctl.md
Name: phase_sweep_ctl

Overview:
- Sequencer for the I/Q demodulator's phase offset input.
- On start, steps the demodulator phase through STEPS equally spaced offsets.
- At each offset it discards SETTLE_N result strobes, then accumulates 2^AVG_LOG2 magnitude results.
- It reports each step's sum, tracks the strongest offset, and finally parks the phase at the best offset found, so the demod runs phase-aligned to the received signal.

Parameters:
- STEPS, 16: number of phase offsets per sweep (2..256).
- PHASE_START, 16'h0000: phase of step 0.
- PHASE_STEP, 16'h1000: increment between steps, modulo 2^16.
- SETTLE_N, 1: demod results discarded after each phase change (0..15).
- AVG_LOG2, 2: log2 of results accumulated per step (0..4).

Ports:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a sweep.
- abort  in  1  synchronous sweep cancel.
- phase  out  16  phase offset driven to the demodulator.
- demod_rdy  in  1  one-cycle strobe: demod_value valid.
- demod_value  in  8  demodulator magnitude result, unsigned.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse: sweep complete.
- step_valid  out  1  one-cycle pulse: step result valid.
- step_idx  out  8  index of the reported step.
- step_mag  out  8+AVG_LOG2  accumulated magnitude of the reported step.
- best_phase  out  16  phase of the strongest step.
- best_mag  out  8+AVG_LOG2  magnitude of the strongest step.

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE.
  - phase=PHASE_START, best_phase=PHASE_START.
  - busy, done, step_valid, step_idx, step_mag, best_mag all 0.
  - Internal accumulator and counters cleared.
- States: IDLE, SETTLE, ACCUM, COMPARE, DONE. busy=1 in every state except IDLE.
- IDLE:
  - start=1 -> phase<=PHASE_START, step_idx<=0, acc<=0, best_mag<=0, best_phase<=PHASE_START, discard count<=SETTLE_N.
  - Next state is SETTLE, or ACCUM if SETTLE_N=0.
- SETTLE: each demod_rdy decrements the discard count. The rdy that brings the count to 0 is discarded, and the next state is ACCUM.
- ACCUM:
  - Each demod_rdy does acc<=acc+demod_value, with no overflow at width 8+AVG_LOG2.
  - After the 2^AVG_LOG2-th rdy, the next state is COMPARE.
- COMPARE (exactly 1 cycle):
  - step_valid=1, step_mag=acc, step_idx=current index.
  - If acc > best_mag (strict): best_mag<=acc, best_phase<=phase. Ties keep the earlier step.
  - Last step (step_idx=STEPS-1) -> DONE.
  - Otherwise:
    - phase<=phase+PHASE_STEP (wraps mod 2^16).
    - step_idx++, acc<=0, discard count reloaded.
    - Next state is SETTLE, or ACCUM if SETTLE_N=0.
- DONE (1 cycle):
  - done=1, phase<=best_phase (final best, including any update made in the last COMPARE).
  - Next state is IDLE.
- Outputs held between events: step_idx, step_mag, best_phase and best_mag hold until overwritten.
- phase holds in IDLE until the next start.
- Ignored inputs:
  - demod_rdy in IDLE, COMPARE or DONE is ignored and not counted.
  - start while busy is ignored.
- abort (any non-IDLE state): next state is IDLE.
  - No done and no step_valid.
  - phase, best_phase and best_mag keep their current values.
  - abort takes priority over demod_rdy and over state transitions in the same cycle.
- Reset mid-sweep: immediate return to the reset values above.
- Latency per step: SETTLE_N + 2^AVG_LOG2 demod strobes, plus 1 COMPARE cycle. done is asserted 1 cycle after the last COMPARE.

Test Plan:
- Defaults, demod_value=10 on every rdy, rdy every 8 cycles, start pulse:
  - 16 step_valid pulses, each step_mag=40, step_idx 0..15.
  - phase sequence 0x0000, 0x1000 ... 0xF000.
  - done pulse; best_phase=0x0000 (tie rule), best_mag=40; final phase=0x0000.
- demod_value = 50 when phase=0x5000, else 10, SETTLE_N=1:
  - the discarded first rdy after each change is not counted.
  - best_phase=0x5000, best_mag=200, final phase=0x5000.
- AVG_LOG2=4, demod_value=255 constant:
  - step_mag=4080 with no overflow; best_mag=4080.
- PHASE_START=16'hF000, PHASE_STEP=16'h2000, STEPS=3:
  - phases F000, 1000, 3000 (wrap checked).
- Edge cases:
  - abort asserted in ACCUM of step 3 together with demod_rdy -> busy=0 next cycle, no done, phase held at 0x3000.
  - start while busy -> no restart, step_idx continues.
- rst_in asserted asynchronously mid-ACCUM (between clock edges):
  - outputs at reset values immediately.
  - a subsequent start runs a full, clean sweep.
